// File: rtl/udm_bus_arbiter_pkg.sv
// udm_pkg: shared constants and state encoding for the UDM two-master bus arbiter
// Contents: bus width, FSM states, one-hot grant encodings, forced-completion read data.
package udm_pkg;
    localparam int BUS_W = 32;
    typedef enum logic [1:0] {IDLE, BUSY, TO_ACK} state_t;
    localparam logic [1:0] GNT_NONE = 2'b00;
    localparam logic [1:0] GNT_M0 = 2'b01;
    localparam logic [1:0] GNT_M1 = 2'b10;
    localparam logic [BUS_W-1:0] TIMEOUT_RDATA = 32'hDEADBEEF;
endpackage

// File: rtl/udm_bus_arbiter_if.sv
// udm_bus_if: one enb/we/addr/wdata/ack/rdata system-bus link
// master modport: drives enb, we, addr, wdata; receives ack, rdata.
// slave modport: receives enb, we, addr, wdata; drives ack, rdata.
interface udm_bus_if;
    import udm_pkg::*;
    logic enb;
    logic we;
    logic [BUS_W-1:0] addr;
    logic [BUS_W-1:0] wdata;
    logic ack;
    logic [BUS_W-1:0] rdata;
    modport master(output enb, we, addr, wdata, input ack, rdata);
    modport slave(input enb, we, addr, wdata, output ack, rdata);
endinterface

// File: rtl/udm_bus_arbiter_rr_pick.sv
// udm_rr_pick: combinational two-way fixed-priority / round-robin winner select
// Ports: req0/req1 requests, last (1 = m1 owned the previous transaction),
//        win one-hot winner (bit0 = m0, bit1 = m1), 00 when nobody requests.
module udm_rr_pick #(
    parameter int PRIORITY_MODE = 0
) (
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic [1:0] win
);
    // On a round-robin tie m0 wins only if m1 was served last.
    assign win[0] = req0 & ((PRIORITY_MODE != 0) | ~req1 | last);
    assign win[1] = req1 & ~win[0];
endmodule

// File: rtl/udm_bus_arbiter.sv
// udm_bus_arbiter: two-master, one-slave arbiter for the UDM 32-bit system bus
// Ports: clk_i clock, reset_n_i async active-low reset,
//        m0/m1 master-facing links (m0 = UDM debug controller, m1 = processor),
//        bus slave-facing link (registered request, ack/rdata returned),
//        grant_bo one-hot current owner, timeout_o forced-completion pulse.
// Optional: define UDM_BUS_ARB_TIMEOUT_EN to force completion after
//           TIMEOUT_CYCLES BUSY cycles without a slave ack.
module udm_bus_arbiter
    import udm_pkg::*;
#(
    parameter int PRIORITY_MODE = 0,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       clk_i,
    input  logic       reset_n_i,
    udm_bus_if.slave   m0,
    udm_bus_if.slave   m1,
    udm_bus_if.master  bus,
    output logic [1:0] grant_bo,
    output logic       timeout_o
);
    state_t state, state_n;
    logic last;
    logic [1:0] win;
    logic done;
    logic expire;

    udm_rr_pick #(.PRIORITY_MODE(PRIORITY_MODE)) u_pick (
        .req0(m0.enb),
        .req1(m1.enb),
        .last(last),
        .win(win)
    );

`ifdef UDM_BUS_ARB_TIMEOUT_EN
    logic [15:0] cnt;
    // A real ack on the terminal count wins over the timeout.
    assign expire = state == BUSY && !bus.ack && cnt == 16'(TIMEOUT_CYCLES - 1);
    assign timeout_o = state == TO_ACK;
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) cnt <= '0;
        else cnt <= state == BUSY && !bus.ack ? cnt + 16'd1 : '0;
`else
    logic unused_timeout;
    assign unused_timeout = ^16'(TIMEOUT_CYCLES);
    assign expire = 1'b0;
    assign timeout_o = 1'b0;
`endif

    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        done = 1'b0;
        case (state)
            IDLE: state_n = |win ? BUSY : IDLE;
            BUSY: begin
                state_n = bus.ack ? IDLE : expire ? TO_ACK : BUSY;
                done = bus.ack;
            end
            TO_ACK: begin
                state_n = IDLE;
                done = 1'b1;
            end
            default: state_n = IDLE;
        endcase
        m0.ack = done & grant_bo[0];
        m1.ack = done & grant_bo[1];
        m0.rdata = timeout_o & grant_bo[0] ? TIMEOUT_RDATA : bus.rdata;
        m1.rdata = timeout_o & grant_bo[1] ? TIMEOUT_RDATA : bus.rdata;
    end

    // Grant is held through TO_ACK so the forced ack reaches its owner.
    always_ff @(posedge clk_i or negedge reset_n_i)
        if (!reset_n_i) begin
            bus.enb <= 1'b0;
            bus.we <= 1'b0;
            bus.addr <= '0;
            bus.wdata <= '0;
            grant_bo <= GNT_NONE;
            last <= 1'b1;
        end else if (state == IDLE && |win) begin
            bus.enb <= 1'b1;
            bus.we <= win[0] ? m0.we : m1.we;
            bus.addr <= win[0] ? m0.addr : m1.addr;
            bus.wdata <= win[0] ? m0.wdata : m1.wdata;
            grant_bo <= win;
        end else if (done) begin
            bus.enb <= 1'b0;
            bus.we <= 1'b0;
            grant_bo <= GNT_NONE;
            last <= grant_bo[1];
        end else if (expire) begin
            bus.enb <= 1'b0;
            bus.we <= 1'b0;
        end
endmodule

// File: tb/tb_udm_bus_arbiter.sv
// tb_udm_bus_arbiter: self-checking bench for udm_bus_arbiter (round-robin and fixed-priority instances)
module tb_udm_bus_arbiter;
    import udm_pkg::*;

    logic clk_i = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk_i = ~clk_i;

    udm_bus_if i0m0(), i0m1(), i0b(), i1m0(), i1m1(), i1b();
    logic [1:0] g0, g1;
    logic to0, to1;

    udm_bus_arbiter #(.PRIORITY_MODE(0), .TIMEOUT_CYCLES(8)) dut0 (
        .clk_i(clk_i), .reset_n_i(reset_n), .m0(i0m0), .m1(i0m1), .bus(i0b),
        .grant_bo(g0), .timeout_o(to0)
    );
    udm_bus_arbiter #(.PRIORITY_MODE(1), .TIMEOUT_CYCLES(8)) dut1 (
        .clk_i(clk_i), .reset_n_i(reset_n), .m0(i1m0), .m1(i1m1), .bus(i1b),
        .grant_bo(g1), .timeout_o(to1)
    );

    typedef struct { int who; logic [31:0] rd; logic to; } sb_t;
    sb_t q0[$], q1[$];
    int n_cmp = 0, n_bad = 0;

    typedef struct {
        logic r0, r1, we0, we1;
        logic [31:0] a0, a1, d0, d1, rd0, rd1;
        int first;
    } vec_t;
    vec_t tbl[6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %h required %h", nm, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [1:0] gnt(input int d);
        return d != 0 ? g1 : g0;
    endfunction
    function automatic logic benb(input int d);
        return d != 0 ? i1b.enb : i0b.enb;
    endfunction
    function automatic logic bwe(input int d);
        return d != 0 ? i1b.we : i0b.we;
    endfunction
    function automatic logic [31:0] baddr(input int d);
        return d != 0 ? i1b.addr : i0b.addr;
    endfunction
    function automatic logic [31:0] bwdata(input int d);
        return d != 0 ? i1b.wdata : i0b.wdata;
    endfunction

    task automatic set_req(input int d, input int who, input logic en, input logic we,
                           input logic [31:0] a, input logic [31:0] w);
        if (d == 0 && who == 0) begin i0m0.enb = en; i0m0.we = we; i0m0.addr = a; i0m0.wdata = w; end
        else if (d == 0) begin i0m1.enb = en; i0m1.we = we; i0m1.addr = a; i0m1.wdata = w; end
        else if (who == 0) begin i1m0.enb = en; i1m0.we = we; i1m0.addr = a; i1m0.wdata = w; end
        else begin i1m1.enb = en; i1m1.we = we; i1m1.addr = a; i1m1.wdata = w; end
    endtask

    task automatic set_enb(input int d, input int who, input logic en);
        if (d == 0 && who == 0) i0m0.enb = en;
        else if (d == 0) i0m1.enb = en;
        else if (who == 0) i1m0.enb = en;
        else i1m1.enb = en;
    endtask

    task automatic wait_grant(input int d, output int k);
        k = 0;
        step;
        while (!benb(d) && k < 8) begin
            step;
            k++;
        end
        if (!benb(d)) begin
            n_cmp++;
            n_bad++;
            $display("FAIL grant_wait dut%0d: bus_enb_o=0 required 1 within %0d cycles", d, k);
        end
    endtask

    // Hold BUSY two cycles, then pulse the slave ack and expect it at the owner.
    task automatic ack(input int d, input int who, input logic [31:0] rd, input logic keep);
        sb_t e;
        repeat (2) step;
        e.who = who;
        e.rd = rd;
        e.to = 1'b0;
        if (d != 0) begin q1.push_back(e); i1b.ack = 1'b1; i1b.rdata = rd; end
        else begin q0.push_back(e); i0b.ack = 1'b1; i0b.rdata = rd; end
        step;
        if (d != 0) i1b.ack = 1'b0;
        else i0b.ack = 1'b0;
        if (!keep) set_enb(d, who, 1'b0);
        chk("release_grant", 32'(gnt(d)), 32'(GNT_NONE));
        chk("release_enb", 32'(benb(d)), 0);
    endtask

    task automatic run_round(input int idx);
        vec_t v;
        int n, who, k;
        v = tbl[idx];
        set_req(0, 0, v.r0, v.we0, v.a0, v.d0);
        set_req(0, 1, v.r1, v.we1, v.a1, v.d1);
        n = int'(v.r0) + int'(v.r1);
        who = v.first;
        for (int s = 0; s < n; s++) begin
            wait_grant(0, k);
            if (s == 0) chk($sformatf("v%0d_latency", idx), k, 0);
            chk($sformatf("v%0d_grant", idx), 32'(gnt(0)), who != 0 ? 32'(GNT_M1) : 32'(GNT_M0));
            chk($sformatf("v%0d_addr", idx), baddr(0), who != 0 ? v.a1 : v.a0);
            chk($sformatf("v%0d_we", idx), 32'(bwe(0)), who != 0 ? 32'(v.we1) : 32'(v.we0));
            chk($sformatf("v%0d_wdata", idx), bwdata(0), who != 0 ? v.d1 : v.d0);
            ack(0, who, who != 0 ? v.rd1 : v.rd0, 1'b0);
            who = 1 - who;
        end
    endtask

    task automatic mon(input int d);
        logic [1:0] a;
        logic t;
        logic [31:0] rd;
        sb_t e;
        a = d != 0 ? {i1m1.ack, i1m0.ack} : {i0m1.ack, i0m0.ack};
        t = d != 0 ? to1 : to0;
        if (a != 2'b00) begin
            n_cmp++;
            if ((d != 0 ? q1.size() : q0.size()) == 0) begin
                n_bad++;
                $display("FAIL unexpected_ack dut%0d: ack %b required 00", d, a);
            end else begin
                e = d != 0 ? q1.pop_front() : q0.pop_front();
                if (d != 0) rd = a[1] ? i1m1.rdata : i1m0.rdata;
                else rd = a[1] ? i0m1.rdata : i0m0.rdata;
                if (a != (e.who != 0 ? GNT_M1 : GNT_M0) || rd !== e.rd || t !== e.to) begin
                    n_bad++;
                    $display("FAIL ack_sb dut%0d: ack %b rdata %h timeout %b required ack %b rdata %h timeout %b",
                             d, a, rd, t, e.who != 0 ? GNT_M1 : GNT_M0, e.rd, e.to);
                end
            end
        end else if (t) begin
            n_cmp++;
            n_bad++;
            $display("FAIL stray_timeout dut%0d: timeout_o 1 required 0", d);
        end
    endtask

    always @(negedge clk_i)
        if (reset_n) begin
            mon(0);
            mon(1);
        end

    initial begin
        int k, n;
        set_req(0, 0, 0, 0, 0, 0);
        set_req(0, 1, 0, 0, 0, 0);
        set_req(1, 0, 0, 0, 0, 0);
        set_req(1, 1, 0, 0, 0, 0);
        i0b.ack = 0; i0b.rdata = 0; i1b.ack = 0; i1b.rdata = 0;
        tbl[0] = '{r0:1, r1:1, we0:0, we1:0, a0:32'h100, a1:32'h200, d0:0, d1:0,
                   rd0:32'hA5A50100, rd1:32'h12345678, first:0};
        tbl[1] = '{r0:1, r1:0, we0:1, we1:0, a0:32'h10, a1:0, d0:32'hCAFEF00D, d1:0,
                   rd0:32'h0, rd1:0, first:0};
        tbl[2] = '{r0:1, r1:1, we0:1, we1:0, a0:32'h20, a1:32'h300, d0:32'h11112222, d1:0,
                   rd0:32'h0, rd1:32'h33334444, first:1};
        tbl[3] = '{r0:0, r1:1, we0:0, we1:1, a0:0, a1:32'h40, d0:0, d1:32'h4444AAAA,
                   rd0:0, rd1:32'h0, first:1};
        tbl[4] = '{r0:1, r1:1, we0:0, we1:0, a0:32'h50, a1:32'h60, d0:0, d1:0,
                   rd0:32'h5050, rd1:32'h6060, first:0};
        tbl[5] = '{r0:1, r1:0, we0:0, we1:0, a0:32'h70, a1:0, d0:0, d1:0,
                   rd0:32'h7070, rd1:0, first:0};

        repeat (3) step;
        reset_n = 1'b1;
        chk("rst_enb", 32'(i0b.enb), 0);
        chk("rst_we", 32'(i0b.we), 0);
        chk("rst_addr", i0b.addr, 0);
        chk("rst_wdata", i0b.wdata, 0);
        chk("rst_grant", 32'(g0), 32'(GNT_NONE));
        chk("rst_timeout", 32'(to0), 0);

        i0b.ack = 1'b1;
        i0b.rdata = 32'h5555AAAA;
        #1;
        chk("spurious_m0_ack", 32'(i0m0.ack), 0);
        chk("spurious_m1_ack", 32'(i0m1.ack), 0);
        step;
        i0b.ack = 1'b0;
        chk("spurious_enb", 32'(i0b.enb), 0);
        chk("spurious_grant", 32'(g0), 32'(GNT_NONE));

        set_req(0, 1, 1, 0, 32'h500, 0);
        wait_grant(0, k);
        chk("to_grant", 32'(g0), 32'(GNT_M1));
`ifdef UDM_BUS_ARB_TIMEOUT_EN
        n = 0;
        while (i0b.enb && n < 50) begin
            n++;
            step;
        end
        chk("to_busy_cycles", n, 8);
        chk("to_flag", 32'(to0), 1);
        q0.push_back('{who:1, rd:TIMEOUT_RDATA, to:1'b1});
        step;
        set_enb(0, 1, 1'b0);
        chk("to_flag_clear", 32'(to0), 0);
        chk("to_grant_clear", 32'(g0), 32'(GNT_NONE));
`else
        n = 0;
        repeat (20) begin
            n++;
            step;
        end
        chk("no_to_enb_held", 32'(i0b.enb), 1);
        chk("no_to_flag", 32'(to0), 0);
        ack(0, 1, 32'h0BADF00D, 1'b0);
`endif

        for (int i = 0; i < 6; i++) run_round(i);

        set_req(0, 0, 1, 0, 32'h600, 0);
        set_req(0, 1, 1, 1, 32'h700, 32'h77);
        wait_grant(0, k);
        chk("rr_after_m0", 32'(g0), 32'(GNT_M1));
        #2 reset_n = 1'b0;
        #1;
        chk("arst_enb", 32'(i0b.enb), 0);
        chk("arst_we", 32'(i0b.we), 0);
        chk("arst_grant", 32'(g0), 32'(GNT_NONE));
        chk("arst_ack", 32'({i0m1.ack, i0m0.ack}), 0);
        step;
        reset_n = 1'b1;
        wait_grant(0, k);
        chk("post_rst_latency", k, 0);
        chk("post_rst_tie", 32'(g0), 32'(GNT_M0));
        chk("post_rst_addr", i0b.addr, 32'h600);
        ack(0, 0, 32'h66, 1'b0);
        wait_grant(0, k);
        chk("post_rst_m1", 32'(g0), 32'(GNT_M1));
        ack(0, 1, 32'h77, 1'b0);

        set_req(1, 1, 1, 0, 32'h900, 0);
        set_req(1, 0, 1, 1, 32'h800, 32'h80);
        for (int i = 0; i < 3; i++) begin
            wait_grant(1, k);
            chk($sformatf("fp%0d_grant", i), 32'(g1), 32'(GNT_M0));
            chk($sformatf("fp%0d_addr", i), i1b.addr, 32'h800 + 32'(i * 4));
            ack(1, 0, 32'h8000 + 32'(i), 1'b1);
            if (i < 2) set_req(1, 0, 1, 1, 32'h800 + 32'((i + 1) * 4), 32'h80);
            else set_enb(1, 0, 1'b0);
        end
        wait_grant(1, k);
        chk("fp_m1_latency", k, 0);
        chk("fp_m1_grant", 32'(g1), 32'(GNT_M1));
        chk("fp_m1_addr", i1b.addr, 32'h900);
        ack(1, 1, 32'h9999, 1'b0);

        repeat (3) step;
        chk("sb0_drained", q0.size(), 0);
        chk("sb1_drained", q1.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
